mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle MIPS between two requesters.
- Requesters: the core datapath (fetch and load/store accesses, selected via IorD) and the debug port (instruction load and readout of memory for the display).
- Serialises accesses, drives the memory for a fixed number of wait cycles, and returns read data with a done pulse. The control unit holds its state while waiting for core_done.
- Fixed priority to debug, with a starvation guard that forces a core grant after a bounded debug streak.

Parameters:
- ADDR_W, 7: word address width on all address buses.
- MEM_LAT, 2: memory access cycles, ≥1. mem_rdata is valid in the last access cycle.
- MAX_DBG_BURST, 3: consecutive debug grants allowed while core_req is pending before the core is forced in; ≥1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- core_req  in  1  core access request, level, held until core_done
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  core word address
- core_wdata  in  32  core write data
- core_gnt  out  1  one-cycle pulse: core request accepted, inputs latched
- core_rdata  out  32  core read data, registered
- core_done  out  1  one-cycle pulse: core access complete
- dbg_req  in  1  debug access request, level, held until dbg_done
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  ADDR_W  debug word address
- dbg_wdata  in  32  debug write data
- dbg_gnt  out  1  one-cycle pulse: debug request accepted
- dbg_rdata  out  32  debug read data, registered
- dbg_done  out  1  one-cycle pulse: debug access complete
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- busy  out  1  state != IDLE
- owner  out  2  00 none, 01 core, 10 debug

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - All gnt, done, mem_en and mem_we are 0.
  - mem_addr, mem_wdata, core_rdata and dbg_rdata are 0.
  - owner=00; streak counter=0; access counter=0.
  - Reset during ACCESS aborts the transaction: no done is issued and memory is not written after the reset edge.
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE arbitration, evaluated each cycle:
  - Neither request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the core if streak == MAX_DBG_BURST, otherwise grant debug.
- On grant:
  - Latch we, addr and wdata of the winner.
  - Set owner; pulse the winner's gnt on the first ACCESS cycle.
  - Load counter = MEM_LAT-1; go to ACCESS.
- Streak update at each grant:
  - Debug grant with core_req=1: streak++, saturating at MAX_DBG_BURST.
  - Debug grant with core_req=0: streak=0.
  - Core grant: streak=0.
- ACCESS:
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latch and are stable for all MEM_LAT cycles.
  - Counter decrements each cycle.
  - On counter==0, read: capture mem_rdata into the owner's rdata at that edge. Go to DONE.
  - Writes leave rdata unchanged.
- DONE:
  - mem_en=0; owner's done=1 for exactly one cycle.
  - Next state IDLE; owner returns to 00 on entering IDLE.
- Latency: with req rising in cycle 0 while IDLE:
  - gnt is in cycle 1.
  - mem_en is high in cycles 1..MEM_LAT.
  - done is in cycle MEM_LAT+1.
  - The earliest next grant is cycle MEM_LAT+3.
- Request and input rules:
  - A requester still holding req in the IDLE cycle after done is treated as a new request.
  - Requests arriving during ACCESS or DONE wait; they are not lost while held.
  - Dropping req before done does not cancel a granted access.
  - Request inputs changing after grant have no effect.
- The non-owner's rdata holds its last value.

Test Plan:
- Core read only, MEM_LAT=2, memory model returns 0xDEADBEEF at addr 0x05 -> core_gnt at cycle 1, mem_en high cycles 1–2 with mem_addr=0x05, mem_we=0; core_done at cycle 3; core_rdata=0xDEADBEEF; owner 01→00.
- Debug write addr 0x10, data 0x12345678 -> mem_we=1, mem_wdata=0x12345678 for 2 cycles; dbg_done pulses once; dbg_rdata unchanged; core sees no gnt/done.
- core_req and dbg_req rise in the same cycle -> dbg_gnt first; core_gnt issued in the IDLE cycle after dbg_done (cycle 5); no overlap of mem_en owners.
- MAX_DBG_BURST=2, dbg_req held high continuously and core_req held high -> grant order dbg, dbg, core, dbg, dbg, core; streak resets after each core grant.
- rst low for one cycle during the 2nd ACCESS cycle of a core write -> all outputs return to reset values immediately; no core_done; the next access after reset release is arbitrated normally from IDLE.
- MEM_LAT=1, core_req held high across done -> back-to-back transactions, with gnt exactly every 3 cycles and done exactly every 3 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing the unified MIPS instruction/data memory between the core datapath
// and the debug port: fixed debug priority with a bounded-streak guard for the core.
module mem_arbiter #(
  parameter int ADDR_W        = 7,
  parameter int MEM_LAT       = 2,
  parameter int MAX_DBG_BURST = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_gnt,
  output logic [31:0]       core_rdata,
  output logic              core_done,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic [1:0]        owner
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int SW    = $clog2(MAX_DBG_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(MEM_LAT - 1);
  localparam logic [SW-1:0]    STREAK_MAX = SW'(MAX_DBG_BURST);
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CORE = 2'b01;
  localparam logic [1:0] OWN_DBG  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]       streak_q, streak_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                en_q, en_d;
  logic                mwe_q, mwe_d;
  logic                cgnt_q, cgnt_d, dgnt_q, dgnt_d;
  logic                cdone_q, cdone_d, ddone_q, ddone_d;
  logic [31:0]         crdata_q, crdata_d, drdata_q, drdata_d;
  logic                grant_core, grant_dbg;

  // The core wins a contested slot only once debug has used up its streak allowance.
  assign grant_core = core_req && (!dbg_req || (streak_q == STREAK_MAX));
  assign grant_dbg  = dbg_req && !grant_core;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    streak_d = streak_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    en_d     = 1'b0;
    mwe_d    = 1'b0;
    cgnt_d   = 1'b0;
    dgnt_d   = 1'b0;
    cdone_d  = 1'b0;
    ddone_d  = 1'b0;
    crdata_d = crdata_q;
    drdata_d = drdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_core) begin
          state_d  = S_ACCESS;
          owner_d  = OWN_CORE;
          we_d     = core_we;
          addr_d   = core_addr;
          wdata_d  = core_wdata;
          en_d     = 1'b1;
          mwe_d    = core_we;
          cgnt_d   = 1'b1;
          cnt_d    = CNT_INIT;
          streak_d = '0;
        end else if (grant_dbg) begin
          state_d  = S_ACCESS;
          owner_d  = OWN_DBG;
          we_d     = dbg_we;
          addr_d   = dbg_addr;
          wdata_d  = dbg_wdata;
          en_d     = 1'b1;
          mwe_d    = dbg_we;
          dgnt_d   = 1'b1;
          cnt_d    = CNT_INIT;
          if (!core_req)
            streak_d = '0;
          else if (streak_q != STREAK_MAX)
            streak_d = streak_q + 1'b1;
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (owner_q == OWN_CORE) begin
            cdone_d = 1'b1;
            if (!we_q) crdata_d = mem_rdata;
          end else begin
            ddone_d = 1'b1;
            if (!we_q) drdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          en_d  = 1'b1;
          mwe_d = we_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_NONE;
      cnt_q    <= '0;
      streak_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      en_q     <= 1'b0;
      mwe_q    <= 1'b0;
      cgnt_q   <= 1'b0;
      dgnt_q   <= 1'b0;
      cdone_q  <= 1'b0;
      ddone_q  <= 1'b0;
      crdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      en_q     <= en_d;
      mwe_q    <= mwe_d;
      cgnt_q   <= cgnt_d;
      dgnt_q   <= dgnt_d;
      cdone_q  <= cdone_d;
      ddone_q  <= ddone_d;
      crdata_q <= crdata_d;
      drdata_q <= drdata_d;
    end
  end

  assign core_gnt   = cgnt_q;
  assign core_done  = cdone_q;
  assign core_rdata = crdata_q;
  assign dbg_gnt    = dgnt_q;
  assign dbg_done   = ddone_q;
  assign dbg_rdata  = drdata_q;
  assign mem_en     = en_q;
  assign mem_we     = mwe_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = (state_q != S_IDLE);
  assign owner      = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table for single/contended accesses, plus
// sequences for streak fairness, reset abort and MEM_LAT=1 back-to-back traffic.
module tb_mem_arbiter;
  localparam int AW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          core_req, core_we, dbg_req, dbg_we;
  logic [AW-1:0] core_addr, dbg_addr;
  logic [31:0]   core_wdata, dbg_wdata;
  logic          core_gnt, core_done, dbg_gnt, dbg_done;
  logic [31:0]   core_rdata, dbg_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [1:0]    owner;

  mem_arbiter #(.ADDR_W(AW), .MEM_LAT(2), .MAX_DBG_BURST(2)) u_dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rdata(core_rdata), .core_done(core_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  logic [31:0] mem [0:127];
  assign mem_rdata = mem_en ? mem[mem_addr] : 32'h0;
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;

  // Second instance: single-cycle memory for back-to-back traffic
  logic          c1_req, c1_we, d1_req, d1_we;
  logic [AW-1:0] c1_addr, d1_addr, m1_addr;
  logic [31:0]   c1_wdata, d1_wdata, c1_rdata, d1_rdata, m1_wdata, m1_rdata;
  logic          c1_gnt, c1_done, d1_gnt, d1_done, m1_en, m1_we, busy1;
  logic [1:0]    owner1;

  mem_arbiter #(.ADDR_W(AW), .MEM_LAT(1), .MAX_DBG_BURST(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .core_req(c1_req), .core_we(c1_we), .core_addr(c1_addr), .core_wdata(c1_wdata),
    .core_gnt(c1_gnt), .core_rdata(c1_rdata), .core_done(c1_done),
    .dbg_req(d1_req), .dbg_we(d1_we), .dbg_addr(d1_addr), .dbg_wdata(d1_wdata),
    .dbg_gnt(d1_gnt), .dbg_rdata(d1_rdata), .dbg_done(d1_done),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata), .busy(busy1), .owner(owner1)
  );
  assign m1_rdata = m1_en ? ({25'd0, m1_addr} ^ 32'h5A00_0000) : 32'h0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        cr, cw;
    logic [6:0]  ca;
    logic [31:0] cd;
    logic        dr, dw;
    logic [6:0]  da;
    logic [31:0] dd;
    logic [5:0]  fl;     // {core_gnt, core_done, dbg_gnt, dbg_done, mem_en, mem_we}
    logic [6:0]  ea;
    logic [31:0] ew;
    logic [1:0]  eo;
    logic        eb;
    logic [31:0] ecr, edr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t V(input logic cr, cw, input logic [6:0] ca, input logic [31:0] cd,
                             input logic dr, dw, input logic [6:0] da, input logic [31:0] dd,
                             input logic [5:0] fl, input logic [6:0] ea, input logic [31:0] ew,
                             input logic [1:0] eo, input logic eb, input logic [31:0] ecr, edr);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.fl = fl; v.ea = ea; v.ew = ew; v.eo = eo; v.eb = eb; v.ecr = ecr; v.edr = edr;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int gord[6];
    int gcyc[6];
    int exp_ord[6] = '{2, 2, 1, 2, 2, 1};
    int gcnt, cyc, overlap, ndone, gc, dc, ng, nd;
    int g1[8];
    int dn1[8];

    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[7'h05] = 32'hDEADBEEF;
    mem[7'h06] = 32'hCAFEF00D;
    {core_req, core_we, dbg_req, dbg_we} = '0;
    core_addr = '0; dbg_addr = '0; core_wdata = '0; dbg_wdata = '0;
    {c1_req, c1_we, d1_req, d1_we} = '0;
    c1_addr = '0; d1_addr = '0; c1_wdata = '0; d1_wdata = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst mem_en", mem_en, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst owner", owner, 0);
    chk("rst busy", busy, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst core_rdata", core_rdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // core read 0x05
    vecs.push_back(V(1,0,7'h05,0, 0,0,0,0, 6'b000000, 0,0, 0,0, 0,0));
    vecs.push_back(V(1,0,7'h05,0, 0,0,0,0, 6'b100010, 7'h05,0, 1,1, 0,0));
    vecs.push_back(V(1,0,7'h05,0, 0,0,0,0, 6'b000010, 7'h05,0, 1,1, 0,0));
    vecs.push_back(V(0,0,0,0,     0,0,0,0, 6'b010000, 0,0, 1,1, 32'hDEADBEEF,0));
    vecs.push_back(V(0,0,0,0,     0,0,0,0, 6'b000000, 0,0, 0,0, 32'hDEADBEEF,0));
    // debug write 0x10
    vecs.push_back(V(0,0,0,0, 1,1,7'h10,32'h12345678, 6'b000000, 0,0, 0,0, 32'hDEADBEEF,0));
    vecs.push_back(V(0,0,0,0, 1,1,7'h10,32'h12345678, 6'b001011, 7'h10,32'h12345678, 2,1, 32'hDEADBEEF,0));
    vecs.push_back(V(0,0,0,0, 1,1,7'h10,32'h12345678, 6'b000011, 7'h10,32'h12345678, 2,1, 32'hDEADBEEF,0));
    vecs.push_back(V(0,0,0,0, 0,0,0,0, 6'b000100, 0,0, 2,1, 32'hDEADBEEF,0));
    vecs.push_back(V(0,0,0,0, 0,0,0,0, 6'b000000, 0,0, 0,0, 32'hDEADBEEF,0));
    // simultaneous requests: debug first, core in the IDLE cycle after dbg_done
    vecs.push_back(V(1,0,7'h06,0, 1,0,7'h10,0, 6'b000000, 0,0, 0,0, 32'hDEADBEEF,0));
    vecs.push_back(V(1,0,7'h06,0, 1,0,7'h10,0, 6'b001010, 7'h10,0, 2,1, 32'hDEADBEEF,0));
    vecs.push_back(V(1,0,7'h06,0, 1,0,7'h10,0, 6'b000010, 7'h10,0, 2,1, 32'hDEADBEEF,0));
    vecs.push_back(V(1,0,7'h06,0, 0,0,0,0,     6'b000100, 0,0, 2,1, 32'hDEADBEEF,32'h12345678));
    vecs.push_back(V(1,0,7'h06,0, 0,0,0,0,     6'b000000, 0,0, 0,0, 32'hDEADBEEF,32'h12345678));
    vecs.push_back(V(1,0,7'h06,0, 0,0,0,0,     6'b100010, 7'h06,0, 1,1, 32'hDEADBEEF,32'h12345678));
    vecs.push_back(V(1,0,7'h06,0, 0,0,0,0,     6'b000010, 7'h06,0, 1,1, 32'hDEADBEEF,32'h12345678));
    vecs.push_back(V(0,0,0,0,     0,0,0,0,     6'b010000, 0,0, 1,1, 32'hCAFEF00D,32'h12345678));
    vecs.push_back(V(0,0,0,0,     0,0,0,0,     6'b000000, 0,0, 0,0, 32'hCAFEF00D,32'h12345678));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      core_req = vecs[i].cr; core_we = vecs[i].cw; core_addr = vecs[i].ca; core_wdata = vecs[i].cd;
      dbg_req  = vecs[i].dr; dbg_we  = vecs[i].dw; dbg_addr  = vecs[i].da; dbg_wdata  = vecs[i].dd;
      @(negedge clk);
      chk($sformatf("v%0d core_gnt", i), core_gnt, vecs[i].fl[5]);
      chk($sformatf("v%0d core_done", i), core_done, vecs[i].fl[4]);
      chk($sformatf("v%0d dbg_gnt", i), dbg_gnt, vecs[i].fl[3]);
      chk($sformatf("v%0d dbg_done", i), dbg_done, vecs[i].fl[2]);
      chk($sformatf("v%0d mem_en", i), mem_en, vecs[i].fl[1]);
      chk($sformatf("v%0d mem_we", i), mem_we, vecs[i].fl[0]);
      chk($sformatf("v%0d owner", i), owner, vecs[i].eo);
      chk($sformatf("v%0d busy", i), busy, vecs[i].eb);
      chk($sformatf("v%0d core_rdata", i), core_rdata, vecs[i].ecr);
      chk($sformatf("v%0d dbg_rdata", i), dbg_rdata, vecs[i].edr);
      if (vecs[i].fl[1]) chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].ea);
      if (vecs[i].fl[1] && vecs[i].fl[0]) chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].ew);
    end
    chk("mem[0x10] after dbg write", mem[7'h10], 32'h12345678);

    // both requests held: grant order follows the debug streak limit of 2
    @(posedge clk); #1;
    core_req = 1; core_we = 0; core_addr = 7'h06;
    dbg_req = 1; dbg_we = 0; dbg_addr = 7'h10;
    gcnt = 0; cyc = 0; overlap = 0;
    while (gcnt < 6 && cyc < 60) begin
      @(negedge clk);
      if (core_gnt && dbg_gnt) overlap++;
      if (core_gnt || dbg_gnt) begin
        gord[gcnt] = core_gnt ? 1 : 2;
        gcyc[gcnt] = cyc;
        gcnt++;
      end
      cyc++;
    end
    core_req = 0; dbg_req = 0;
    chk("streak grant count", gcnt, 6);
    chk("streak gnt overlap", overlap, 0);
    for (int i = 0; i < gcnt; i++) chk($sformatf("streak order %0d", i), gord[i], exp_ord[i]);
    for (int i = 1; i < gcnt; i++) chk($sformatf("streak spacing %0d", i), gcyc[i] - gcyc[i-1], 4);
    cyc = 0;
    while (busy && cyc < 10) begin @(negedge clk); cyc++; end
    chk("streak drain idle", busy, 0);

    // reset in the 2nd access cycle of a core write
    @(posedge clk); #1;
    core_req = 1; core_we = 1; core_addr = 7'h20; core_wdata = 32'hAAAA5555;
    @(posedge clk); @(negedge clk);
    chk("rstabort gnt", core_gnt, 1);
    chk("rstabort mem_we", mem_we, 1);
    @(posedge clk); #1;
    rst = 1'b0; core_req = 0;
    #1;
    chk("rstabort mem_en", mem_en, 0);
    chk("rstabort mem_we0", mem_we, 0);
    chk("rstabort mem_addr", mem_addr, 0);
    chk("rstabort mem_wdata", mem_wdata, 0);
    chk("rstabort owner", owner, 0);
    chk("rstabort busy", busy, 0);
    chk("rstabort core_rdata", core_rdata, 0);
    chk("rstabort dbg_rdata", dbg_rdata, 0);
    @(posedge clk); #1 rst = 1'b1;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (core_done || mem_en) ndone++;
    end
    chk("rstabort no done/mem_en", ndone, 0);
    @(posedge clk); #1;
    core_req = 1; core_we = 0; core_addr = 7'h06;
    gc = -1; dc = -1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (core_gnt && gc < 0) gc = k;
      if (core_done && dc < 0) begin dc = k; core_req = 0; end
    end
    chk("postrst gnt cycle", gc, 1);
    chk("postrst done cycle", dc, 3);
    chk("postrst core_rdata", core_rdata, 32'hCAFEF00D);

    // MEM_LAT=1, core_req held: a transaction every 3 cycles
    @(posedge clk); #1;
    c1_req = 1; c1_we = 0; c1_addr = 7'h33;
    ng = 0; nd = 0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (c1_gnt && ng < 8) begin g1[ng] = k; ng++; end
      if (c1_done && nd < 8) begin dn1[nd] = k; nd++; end
    end
    c1_req = 0;
    chk("b2b gnt count", ng, 4);
    chk("b2b done count", nd, 4);
    for (int i = 0; i < 4 && i < ng; i++) chk($sformatf("b2b gnt %0d", i), g1[i], 1 + 3*i);
    for (int i = 0; i < 4 && i < nd; i++) chk($sformatf("b2b done %0d", i), dn1[i], 2 + 3*i);
    chk("b2b core_rdata", c1_rdata, 32'h5A000033);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
